// File: rtl/video_timing_pkg.sv
// Shared types and presets for the raster timing generator.
//   timing_t      : one raster mode (all fields are counts/positions in pixels or lines)
//   MODE_6M/4M    : arcade presets
//   DEFAULT_MODES : preset table, index 0 = MODE_6M, index 1 = MODE_4M
//   wrap_add      : add a small signed offset to a position and wrap it into [0, total)
package video_timing_pkg;

  localparam int TW = 16;

  typedef struct packed {
    logic [TW-1:0] h_total;
    logic [TW-1:0] h_bl_start;
    logic [TW-1:0] hs_start;
    logic [TW-1:0] hs_end;
    logic [TW-1:0] v_total;
    logic [TW-1:0] vbl_start;
    logic [TW-1:0] vbl_end;
    logic [TW-1:0] vs_start;
    logic [TW-1:0] vs_end;
  } timing_t;

  localparam timing_t MODE_6M = '{16'd384, 16'd256, 16'd288, 16'd320,
                                  16'd262, 16'd240, 16'd16, 16'd244, 16'd247};
  localparam timing_t MODE_4M = '{16'd264, 16'd256, 16'd256, 16'd258,
                                  16'd256, 16'd224, 16'd0, 16'd232, 16'd236};

  localparam timing_t [0:1] DEFAULT_MODES = '{MODE_6M, MODE_4M};

  // Offsets are at most 8 and every total is larger, so one correction step suffices.
  function automatic logic [TW-1:0] wrap_add(input logic [TW-1:0] value,
                                             input logic signed [3:0] offset,
                                             input logic [TW-1:0] total);
    logic signed [TW:0] sum;
    logic signed [TW:0] tot;
    tot = $signed({1'b0, total});
    sum = $signed({1'b0, value}) + (TW+1)'(offset);
    if (sum < 0) sum = sum + tot;
    else if (sum >= tot) sum = sum - tot;
    return sum[TW-1:0];
  endfunction

endpackage

// File: rtl/video_timing_gen_sync_window.sv
// sync_window: registered sync level for one raster axis.
//   clk, reset_n : clock, async active-low reset
//   step         : pixel-clock enable; sync only updates when high
//   en           : extra update gate (tied high for horizontal, hsync leading edge for vertical)
//   cnt          : next count on this axis
//   start, stop  : nominal window [start, stop) from the mode table
//   off          : signed shift applied to both bounds
//   total        : axis length used for wrapping
//   sync         : registered in-window flag
module sync_window
  import video_timing_pkg::*;
#(
  parameter int W = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 step,
  input  logic                 en,
  input  logic [W-1:0]         cnt,
  input  logic [TW-1:0]        start,
  input  logic [TW-1:0]        stop,
  input  logic signed [3:0]    off,
  input  logic [TW-1:0]        total,
  output logic                 sync
);

  logic [W-1:0] s_eff;
  logic [W-1:0] e_eff;
  logic         in_win;

  // When the shifted start lands after the shifted end, the window straddles the wrap.
  always_comb begin
    s_eff = W'(wrap_add(start, off, total));
    e_eff = W'(wrap_add(stop, off, total));
    if (s_eff <= e_eff) in_win = (cnt >= s_eff) && (cnt < e_eff);
    else                in_win = (cnt >= s_eff) || (cnt < e_eff);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= 1'b0;
    else if (step && en) sync <= in_win;
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: multi-mode raster timing generator.
//   clk, reset_n         : system clock, async active-low reset
//   clk_pix              : pixel enable; counters advance only when high
//   mode_sel             : requested mode, taken at the frame boundary
//   hs_offset, vs_offset : signed sync shifts, taken at the frame boundary
//   hc, vc               : pixel / line counters
//   hbl, vbl, de         : blanking and display enable
//   hsync, vsync         : active-high sync
//   line_start, frame_start, vbl_irq : single-clk strobes
//   mode_active          : mode currently in force
// All levels are registered from next-count values so they line up with hc/vc.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int                      W            = 9,
  parameter int                      NUM_MODES    = 2,
  parameter timing_t [0:NUM_MODES-1] MODES        = DEFAULT_MODES,
  parameter int                      MODE_DEFAULT = 0,
  localparam int                     MW           = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clk_pix,
  input  logic [MW-1:0]        mode_sel,
  input  logic signed [3:0]    hs_offset,
  input  logic signed [3:0]    vs_offset,
  output logic [W-1:0]         hc,
  output logic [W-1:0]         vc,
  output logic                 hbl,
  output logic                 vbl,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 line_start,
  output logic                 frame_start,
  output logic                 vbl_irq,
  output logic [MW-1:0]        mode_active
);

  logic signed [3:0] hs_off, vs_off;
  logic signed [3:0] hs_off_nxt, vs_off_nxt;
  logic [MW-1:0]     mode_nxt;
  logic              last_h, frame_end;
  logic [W-1:0]      hc_nxt, vc_nxt;
  logic              hbl_nxt, vbl_nxt;
  logic [W-1:0]      hs_eff;

  // At the frame boundary the next position is 0,0 and must already be judged
  // against the newly selected table and offsets.
  always_comb begin
    last_h    = (hc == W'(MODES[mode_active].h_total) - W'(1));
    frame_end = last_h && (vc == W'(MODES[mode_active].v_total) - W'(1));
    hc_nxt    = last_h ? '0 : hc + W'(1);
    vc_nxt    = vc;
    if (last_h) vc_nxt = frame_end ? '0 : vc + W'(1);

    mode_nxt   = mode_active;
    hs_off_nxt = hs_off;
    vs_off_nxt = vs_off;
    if (frame_end) begin
      if (int'(mode_sel) < NUM_MODES) mode_nxt = mode_sel;
      hs_off_nxt = hs_offset;
      vs_off_nxt = vs_offset;
    end

    hbl_nxt = (hc_nxt >= W'(MODES[mode_nxt].h_bl_start));
    vbl_nxt = (vc_nxt >= W'(MODES[mode_nxt].vbl_start)) ||
              (vc_nxt <  W'(MODES[mode_nxt].vbl_end));
  end

  assign hs_eff = W'(wrap_add(MODES[mode_nxt].hs_start, hs_off_nxt, MODES[mode_nxt].h_total));

  sync_window #(.W(W)) u_hwin (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (clk_pix),
    .en      (1'b1),
    .cnt     (hc_nxt),
    .start   (MODES[mode_nxt].hs_start),
    .stop    (MODES[mode_nxt].hs_end),
    .off     (hs_off_nxt),
    .total   (MODES[mode_nxt].h_total),
    .sync    (hsync)
  );

  // vsync only moves on the hsync leading edge.
  sync_window #(.W(W)) u_vwin (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (clk_pix),
    .en      (hc_nxt == hs_eff),
    .cnt     (vc_nxt),
    .start   (MODES[mode_nxt].vs_start),
    .stop    (MODES[mode_nxt].vs_end),
    .off     (vs_off_nxt),
    .total   (MODES[mode_nxt].v_total),
    .sync    (vsync)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc          <= '0;
      vc          <= '0;
      hbl         <= 1'b0;
      vbl         <= 1'b0;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vbl_irq     <= 1'b0;
      mode_active <= MW'(MODE_DEFAULT);
      hs_off      <= '0;
      vs_off      <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vbl_irq     <= 1'b0;
      if (clk_pix) begin
        hc          <= hc_nxt;
        vc          <= vc_nxt;
        mode_active <= mode_nxt;
        hs_off      <= hs_off_nxt;
        vs_off      <= vs_off_nxt;
        hbl         <= hbl_nxt;
        vbl         <= vbl_nxt;
        de          <= ~hbl_nxt & ~vbl_nxt;
        line_start  <= last_h;
        frame_start <= frame_end;
        vbl_irq     <= vbl_nxt & ~vbl;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen: three modes (the two presets plus a tiny raster
// that keeps frames short), random pixel enables and offsets, a behavioural
// raster model compared every clk, and literal spot checks at known positions.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  localparam timing_t MODE_TINY = '{16'd40, 16'd32, 16'd34, 16'd38,
                                    16'd20, 16'd16, 16'd2, 16'd17, 16'd19};
  localparam timing_t [0:2] TB_MODES = '{MODE_6M, MODE_4M, MODE_TINY};
  localparam int NMODES = 3;
  localparam int DEF_MODE = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_pix;
  logic [1:0] mode_sel;
  logic [3:0] hs_offset, vs_offset;
  logic [8:0] hc, vc;
  logic       hbl, vbl, hsync, vsync, de, line_start, frame_start, vbl_irq;
  logic [1:0] mode_active;

  always #5 clk = ~clk;

  video_timing_gen #(
    .W(9), .NUM_MODES(NMODES), .MODES(TB_MODES), .MODE_DEFAULT(DEF_MODE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_pix(clk_pix), .mode_sel(mode_sel),
    .hs_offset(hs_offset), .vs_offset(vs_offset), .hc(hc), .vc(vc),
    .hbl(hbl), .vbl(vbl), .hsync(hsync), .vsync(vsync), .de(de),
    .line_start(line_start), .frame_start(frame_start), .vbl_irq(vbl_irq),
    .mode_active(mode_active)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // model state
  int m_hc, m_vc, m_mode, m_hoff, m_voff;
  bit e_hbl, e_vbl, e_hs, e_vs, e_de, e_ls, e_fs, e_irq;

  int pix_pol = 0;
  int div = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int md(input int x, input int t);
    return ((x % t) + t) % t;
  endfunction

  // c lies in [s, e) on a circle of length t
  function automatic bit inwin(input int c, input int s, input int e, input int t);
    return md(c - s, t) < md(e - s, t);
  endfunction

  task automatic model_reset();
    m_hc = 0; m_vc = 0; m_mode = DEF_MODE; m_hoff = 0; m_voff = 0;
    e_hbl = 0; e_vbl = 0; e_hs = 0; e_vs = 0; e_de = 0; e_ls = 0; e_fs = 0; e_irq = 0;
  endtask

  task automatic model_update(input bit pix);
    timing_t t;
    int ht, vt, hs0;
    bit prev_vbl;
    e_ls = 0; e_fs = 0; e_irq = 0;
    if (!pix) return;
    t  = TB_MODES[m_mode];
    ht = int'(t.h_total);
    vt = int'(t.v_total);
    if (m_hc == ht - 1 && m_vc == vt - 1) begin
      if (int'(mode_sel) < NMODES) m_mode = int'(mode_sel);
      m_hoff = int'($signed(hs_offset));
      m_voff = int'($signed(vs_offset));
    end
    m_hc = (m_hc + 1) % ht;
    if (m_hc == 0) m_vc = (m_vc + 1) % vt;
    t  = TB_MODES[m_mode];
    ht = int'(t.h_total);
    vt = int'(t.v_total);
    prev_vbl = e_vbl;
    e_hbl = (m_hc >= int'(t.h_bl_start));
    e_vbl = (m_vc >= int'(t.vbl_start)) || (m_vc < int'(t.vbl_end));
    e_de  = !e_hbl && !e_vbl;
    e_irq = e_vbl && !prev_vbl;
    e_ls  = (m_hc == 0);
    e_fs  = (m_hc == 0) && (m_vc == 0);
    e_hs  = inwin(m_hc, int'(t.hs_start) + m_hoff, int'(t.hs_end) + m_hoff, ht);
    hs0   = md(int'(t.hs_start) + m_hoff, ht);
    if (m_hc == hs0)
      e_vs = inwin(m_vc, int'(t.vs_start) + m_voff, int'(t.vs_end) + m_voff, vt);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("hc", hc, m_hc);
      chk("vc", vc, m_vc);
      chk("hbl", hbl, e_hbl);
      chk("vbl", vbl, e_vbl);
      chk("de", de, e_de);
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("line_start", line_start, e_ls);
      chk("frame_start", frame_start, e_fs);
      chk("vbl_irq", vbl_irq, e_irq);
      chk("mode_active", mode_active, m_mode);
    end
  end

  task automatic tick(input bit p);
    clk_pix = p;
    @(posedge clk);
    #1;
    model_update(p);
  endtask

  task automatic tick_auto();
    bit p;
    case (pix_pol)
      0: p = 1'b1;
      1: begin p = (div == 3); div = (div + 1) % 4; end
      default: p = ($urandom_range(0, 3) != 0);
    endcase
    tick(p);
  endtask

  task automatic run_until(input int h, input int v);
    int n;
    n = 0;
    do begin
      tick_auto();
      n++;
    end while (!(m_hc == h && m_vc == v) && n < 60000);
    if (!(m_hc == h && m_vc == v)) chk("run_until_timeout", n, -1);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_hc", hc, 0);
    chk("rst_vc", vc, 0);
    chk("rst_levels", {hbl, vbl, hsync, vsync, de}, 0);
    chk("rst_strobes", {line_start, frame_start, vbl_irq}, 0);
    chk("rst_mode", mode_active, DEF_MODE);
    @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; clk_pix = 1'b0; mode_sel = 2'd2; hs_offset = '0; vs_offset = '0;
    model_reset();
    do_reset();
    chk_en = 1;

    // first tiny frame, random enables: vsync rises on the hsync leading edge at line 17
    pix_pol = 2;
    run_until(33, 17); chk("tiny_vs@33,17", vsync, 0);
    run_until(34, 17); chk("tiny_vs@34,17", vsync, 1); chk("tiny_hs@34,17", hsync, 1);
    run_until(0, 0);   chk("tiny_fs", frame_start, 1);

    // random offsets and mode_sel in {2, 3(invalid)}
    repeat (10000) begin
      if ($urandom_range(0, 7) == 0) begin
        hs_offset = 4'($urandom);
        vs_offset = 4'($urandom);
        mode_sel  = ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd3;
      end
      tick_auto();
    end
    mode_sel = 2'd3;
    run_until(0, 0); chk("invalid_mode_kept", mode_active, 2);

    // pixel enable held low mid-line
    run_until(20, 5);
    repeat (50) begin
      tick(1'b0);
      chk("hold_strobes", {line_start, frame_start, vbl_irq}, 0);
    end
    chk("hold_hc", hc, 20);
    chk("hold_vc", vc, 5);

    // switch to mode 0, enable every 4th clk for the first line
    mode_sel = 2'd0; hs_offset = '0; vs_offset = '0; pix_pol = 0;
    run_until(0, 0);
    chk("m0_mode", mode_active, 0); chk("m0_fs", frame_start, 1); chk("m0_vbl@0", vbl, 1);
    pix_pol = 1;
    run_until(255, 0); chk("m0_hbl@255", hbl, 0);
    run_until(256, 0); chk("m0_hbl@256", hbl, 1);
    run_until(287, 0); chk("m0_hs@287", hsync, 0);
    run_until(288, 0); chk("m0_hs@288", hsync, 1);
    run_until(319, 0); chk("m0_hs@319", hsync, 1);
    run_until(320, 0); chk("m0_hs@320", hsync, 0);
    mode_sel = 2'd1; pix_pol = 0;
    run_until(383, 15); chk("m0_vbl@15", vbl, 1);
    run_until(0, 16);
    chk("m0_vbl@16", vbl, 0); chk("m0_ls", line_start, 1); chk("m0_mode_held", mode_active, 0);
    run_until(200, 16);
    do_reset();

    // mode 1 with hsync shifted +7: window wraps to hc 263, 0
    mode_sel = 2'd1; hs_offset = 4'd7;
    run_until(0, 0);
    chk("m1_mode", mode_active, 1); chk("m1_vbl@0", vbl, 0);
    run_until(262, 0); chk("m1p7_hs@262", hsync, 0);
    run_until(263, 0); chk("m1p7_hs@263", hsync, 1);
    run_until(0, 1);   chk("m1p7_hs@0", hsync, 1);
    run_until(1, 1);   chk("m1p7_hs@1", hsync, 0);
    do_reset();

    // mode 1 with hsync shifted -8: hc 248..249
    mode_sel = 2'd1; hs_offset = 4'h8;
    run_until(0, 0);
    run_until(247, 0); chk("m1m8_hs@247", hsync, 0);
    run_until(248, 0); chk("m1m8_hs@248", hsync, 1);
    run_until(249, 0); chk("m1m8_hs@249", hsync, 1);
    run_until(250, 0); chk("m1m8_hs@250", hsync, 0);
    do_reset();

    // tiny mode, vsync shifted -3: lines 14..15, edges at hc 34
    mode_sel = 2'd2; hs_offset = '0; vs_offset = 4'hD;
    run_until(0, 0);
    run_until(33, 14); chk("vsm3@33,14", vsync, 0);
    run_until(34, 14); chk("vsm3@34,14", vsync, 1);
    run_until(33, 16); chk("vsm3@33,16", vsync, 1);
    run_until(34, 16); chk("vsm3@34,16", vsync, 0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
